// File: rtl/aes_block_loader_pkg.sv
// Shared constants for the AES byte-serial loader: phase encodings, key-length codes,
// byte counts and the key-length helper functions.
package aes_block_loader_pkg;

  localparam int TEXT_BYTES    = 16;
  localparam int MAX_KEY_BYTES = 32;

  localparam int KEY128_BYTES = 16;
  localparam int KEY192_BYTES = 24;
  localparam int KEY256_BYTES = 32;

  typedef enum logic [1:0] {
    PH_IDLE      = 2'd0,
    PH_LOAD_TEXT = 2'd1,
    PH_LOAD_KEY  = 2'd2,
    PH_DONE      = 2'd3
  } phase_t;

  localparam logic [1:0] KL_128 = 2'd0;
  localparam logic [1:0] KL_192 = 2'd1;
  localparam logic [1:0] KL_256 = 2'd2;

  // Code 3 is undefined for AES and falls back to 128-bit.
  function automatic logic [1:0] norm_key_sel(input logic [1:0] sel);
    return (sel == 2'd3) ? KL_128 : sel;
  endfunction

  function automatic logic [5:0] key_last_idx(input logic [1:0] ks);
    case (ks)
      KL_192:  return 6'(KEY192_BYTES - 1);
      KL_256:  return 6'(KEY256_BYTES - 1);
      default: return 6'(KEY128_BYTES - 1);
    endcase
  endfunction

endpackage

// File: rtl/aes_byte_sink.sv
// N-byte register filled one byte per write; byte 0 lands in the leftmost lane [0:7].
// The index counter wraps to 0 after the write at last_idx.
module aes_byte_sink #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr,
  input  logic [7:0]       wdata,
  input  logic [5:0]       last_idx,
  output logic [0:8*N-1]   data,
  output logic [5:0]       idx,
  output logic             at_last
);

  assign at_last = (idx == last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      idx  <= '0;
    end else if (clear) begin
      data <= '0;
      idx  <= '0;
    end else if (wr) begin
      for (int b = 0; b < N; b++) begin
        if (idx == 6'(b)) data[8*b +: 8] <= wdata;
      end
      idx <= at_last ? 6'd0 : idx + 6'd1;
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Byte-serial loader for the AES demo: assembles plaintext then key, then pulses go once.
// Valid/ready: a byte transfers on a rising KEY edge when in_valid & in_ready; start overrides it.
module aes_block_loader
  import aes_block_loader_pkg::*;
(
  input  logic                       KEY,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 key_len_sel,
  input  logic                       in_valid,
  input  logic [7:0]                 in_byte,
  output logic                       in_ready,
  output logic [0:8*TEXT_BYTES-1]    text,
  output logic [0:8*MAX_KEY_BYTES-1] key,
  output logic [1:0]                 key_sel,
  output logic [5:0]                 byte_idx,
  output logic [1:0]                 phase,
  output logic                       loaded,
  output logic                       go
);

  phase_t     state;
  logic       xfer;
  logic       text_wr;
  logic       key_wr;
  logic [5:0] text_idx;
  logic [5:0] key_idx;
  logic       text_last;
  logic       key_last;

  assign xfer    = in_valid & in_ready;
  assign text_wr = xfer & ~start & (state == PH_LOAD_TEXT);
  assign key_wr  = xfer & ~start & (state == PH_LOAD_KEY);
  assign phase   = state;

  aes_byte_sink #(.N(TEXT_BYTES)) u_text_sink (
    .clk      (KEY),
    .rst      (rst),
    .clear    (start),
    .wr       (text_wr),
    .wdata    (in_byte),
    .last_idx (6'(TEXT_BYTES - 1)),
    .data     (text),
    .idx      (text_idx),
    .at_last  (text_last)
  );

  aes_byte_sink #(.N(MAX_KEY_BYTES)) u_key_sink (
    .clk      (KEY),
    .rst      (rst),
    .clear    (start),
    .wr       (key_wr),
    .wdata    (in_byte),
    .last_idx (key_last_idx(key_sel)),
    .data     (key),
    .idx      (key_idx),
    .at_last  (key_last)
  );

  // Each sink resets its own counter at phase end, so idle/done phases report 0.
  always_comb begin
    byte_idx = 6'd0;
    case (state)
      PH_LOAD_TEXT: byte_idx = text_idx;
      PH_LOAD_KEY:  byte_idx = key_idx;
      default:      byte_idx = 6'd0;
    endcase
  end

  always_ff @(posedge KEY or posedge rst) begin
    if (rst) begin
      state    <= PH_IDLE;
      key_sel  <= KL_128;
      in_ready <= 1'b0;
      loaded   <= 1'b0;
      go       <= 1'b0;
    end else begin
      go <= 1'b0;
      if (start) begin
        state    <= PH_LOAD_TEXT;
        key_sel  <= norm_key_sel(key_len_sel);
        in_ready <= 1'b1;
        loaded   <= 1'b0;
      end else begin
        case (state)
          PH_LOAD_TEXT: begin
            if (text_wr && text_last) state <= PH_LOAD_KEY;
          end
          PH_LOAD_KEY: begin
            if (key_wr && key_last) begin
              state    <= PH_DONE;
              in_ready <= 1'b0;
              loaded   <= 1'b1;
              go       <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
